// File: rtl/prbs_man_gen.sv
// PRBS / pattern bit generator with NRZ, bit-clock and Manchester outputs.
// One bit = two half-bit periods of BASE_HALF*(rate+1) clocks each.
module prbs_man_gen #(
    parameter int LFSR_N    = 7,
    parameter int RATE_W    = 4,
    parameter int BASE_HALF = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [RATE_W-1:0] rate_sel,
    input  logic [1:0]        mode,
    input  logic [7:0]        pattern,
    output logic              sig_nrz,
    output logic              sig_bclk,
    output logic              sig_man,
    output logic              bit_stb,
    output logic              busy
);

    localparam int TAP = (LFSR_N == 7)  ? 6  :
                         (LFSR_N == 9)  ? 5  :
                         (LFSR_N == 15) ? 14 :
                         (LFSR_N == 23) ? 18 : 0;

    localparam int CNT_W = $clog2(BASE_HALF * (2 ** RATE_W) + 1);

    localparam logic [LFSR_N-1:0] SEED = {LFSR_N{1'b1}};

    if (TAP == 0) begin : g_bad_order
        $error("prbs_man_gen: LFSR_N must be 7, 9, 15 or 23");
    end

    if (BASE_HALF < 1) begin : g_bad_half
        $error("prbs_man_gen: BASE_HALF must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        FIRST_HALF  = 2'd1,
        SECOND_HALF = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_half;
    logic              w_half_end;
    logic              w_start;
    logic [RATE_W-1:0] r_rate;
    logic [1:0]        r_mode;
    logic [2:0]        r_idx;
    logic [2:0]        w_idx_eff;
    logic              w_mode_chg;
    logic [7:0]        r_pat;
    logic [LFSR_N-1:0] r_lfsr;
    logic [LFSR_N-1:0] w_lfsr_cur;
    logic              w_bit;
    logic              r_nrz;
    logic              r_bclk;
    logic              r_man;
    logic              r_stb;
    logic              w_nrz_d;
    logic              w_bclk_d;
    logic              w_stb_d;

    assign w_half     = CNT_W'(BASE_HALF * (int'(r_rate) + 1));
    assign w_half_end = (r_state != IDLE) && (r_cnt == w_half - CNT_W'(1));
    assign w_start    = en && ((r_state == IDLE) ||
                               (r_state == SECOND_HALF && w_half_end));
    assign w_mode_chg = (mode != r_mode);
    assign w_idx_eff  = w_mode_chg ? 3'd0 : r_idx;
    assign w_lfsr_cur = (r_lfsr == '0) ? SEED : r_lfsr;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: each half lasts exactly HALF cycles; en only matters at bit edges
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:        if (en) w_next = FIRST_HALF;
            FIRST_HALF:  if (w_half_end) w_next = SECOND_HALF;
            SECOND_HALF: if (w_half_end) w_next = en ? FIRST_HALF : IDLE;
            default:     w_next = IDLE;
        endcase
    end

    // Data bit for a new bit period, chosen from the mode being latched
    always_comb begin
        w_bit = 1'b0;
        unique case (mode)
            2'b00:   w_bit = w_lfsr_cur[LFSR_N-1];
            2'b01:   w_bit = (w_idx_eff == 3'd0) ? pattern[7]
                                                 : r_pat[3'd7 - w_idx_eff];
            2'b10:   w_bit = 1'b1;
            default: w_bit = ~w_idx_eff[0];
        endcase
    end

    // Next output values, registered below so sig_man tracks sig_bclk exactly
    always_comb begin
        w_nrz_d  = 1'b0;
        w_bclk_d = 1'b0;
        w_stb_d  = 1'b0;
        unique case (w_next)
            FIRST_HALF: begin
                w_nrz_d  = w_start ? w_bit : r_nrz;
                w_bclk_d = 1'b1;
                w_stb_d  = w_start;
            end
            SECOND_HALF: w_nrz_d = r_nrz;
            default: ;
        endcase
    end

    // Half-period counter and per-bit latches (rate, mode, index, pattern, LFSR)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_rate <= '0;
            r_mode <= 2'b00;
            r_idx  <= 3'd0;
            r_pat  <= 8'h00;
            r_lfsr <= SEED;
        end else begin
            if (w_half_end || r_state == IDLE) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_start) begin
                r_rate <= rate_sel;
                r_mode <= mode;
                if (mode == 2'b01 || mode == 2'b11) begin
                    r_idx <= w_idx_eff + 3'd1;
                end else if (w_mode_chg) begin
                    r_idx <= 3'd0;
                end
                if (mode == 2'b01 && w_idx_eff == 3'd0) begin
                    r_pat <= pattern;
                end
                if (mode == 2'b00) begin
                    r_lfsr <= {w_lfsr_cur[LFSR_N-2:0],
                               w_lfsr_cur[LFSR_N-1] ^ w_lfsr_cur[TAP-1]};
                end
            end
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nrz  <= 1'b0;
            r_bclk <= 1'b0;
            r_man  <= 1'b0;
            r_stb  <= 1'b0;
        end else begin
            r_nrz  <= w_nrz_d;
            r_bclk <= w_bclk_d;
            r_man  <= w_nrz_d ^ w_bclk_d;
            r_stb  <= w_stb_d;
        end
    end

    assign sig_nrz  = r_nrz;
    assign sig_bclk = r_bclk;
    assign sig_man  = r_man;
    assign bit_stb  = r_stb;
    assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_prbs_man_gen.sv
// Bench for prbs_man_gen: bit-position reference model checked every cycle,
// plus directed checks on PRBS, rate, pattern, modes, en drop and reset.
module tb_prbs_man_gen;

    localparam int N  = 7;
    localparam int RW = 4;
    localparam int BH = 2;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          en       = 1'b0;
    logic [RW-1:0] rate_sel = '0;
    logic [1:0]    mode     = 2'b00;
    logic [7:0]    pattern  = 8'h00;
    logic          sig_nrz;
    logic          sig_bclk;
    logic          sig_man;
    logic          bit_stb;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;

    bit seq [0:253];

    int         m_pos  = 0;
    int         m_half = 0;
    int         m_k    = 0;
    int         m_idx  = 0;
    bit         m_busy = 1'b0;
    bit         m_bit  = 1'b0;
    logic [1:0] m_last = 2'b00;
    logic [7:0] m_cap  = 8'h00;

    prbs_man_gen #(
        .LFSR_N    (N),
        .RATE_W    (RW),
        .BASE_HALF (BH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .rate_sel (rate_sel),
        .mode     (mode),
        .pattern  (pattern),
        .sig_nrz  (sig_nrz),
        .sig_bclk (sig_bclk),
        .sig_man  (sig_man),
        .bit_stb  (bit_stb),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: begin a new bit using the inputs present at this edge
    task automatic start_bit();
        m_half = BH * (int'(rate_sel) + 1);
        m_pos  = 0;
        m_busy = 1'b1;
        if (mode != m_last) m_idx = 0;
        m_last = mode;
        case (mode)
            2'b00: begin
                m_bit = seq[m_k];
                m_k   = (m_k + 1) % 127;
            end
            2'b01: begin
                if (m_idx == 0) m_cap = pattern;
                m_bit = m_cap[7 - m_idx];
                m_idx = (m_idx + 1) % 8;
            end
            2'b10: m_bit = 1'b1;
            default: begin
                m_bit = (m_idx % 2 == 0);
                m_idx = (m_idx + 1) % 8;
            end
        endcase
    endtask

    // Reference model step and per-cycle compare
    initial begin
        logic [4:0] exp_v;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                m_busy = 1'b0;
                m_pos  = 0;
                m_half = 0;
                m_k    = 0;
                m_idx  = 0;
                m_bit  = 1'b0;
                m_last = 2'b00;
            end else if (m_busy) begin
                m_pos++;
                if (m_pos == 2 * m_half) begin
                    if (en) start_bit();
                    else m_busy = 1'b0;
                end
            end else if (en) begin
                start_bit();
            end
            exp_v[4] = m_busy;
            exp_v[3] = m_busy & m_bit;
            exp_v[2] = m_busy && (m_pos < m_half);
            exp_v[1] = exp_v[3] ^ exp_v[2];
            exp_v[0] = m_busy && (m_pos == 0);
            check("cycle{busy,nrz,bclk,man,stb}",
                  {27'd0, busy, sig_nrz, sig_bclk, sig_man, bit_stb},
                  {27'd0, exp_v});
        end
    end

    task automatic next_stb(output int gap);
        gap = 0;
        do begin
            @(posedge clk);
            #1;
            gap++;
        end while (!bit_stb && gap < 200);
        if (!bit_stb) begin
            n_cmp++;
            n_err++;
            $display("FAIL stb_timeout: got no bit_stb want one within 200 cycles");
        end
    endtask

    task automatic collect(input int n, output logic [31:0] bits);
        int g;
        bits = '0;
        for (int i = 0; i < n; i++) begin
            next_stb(g);
            bits = {bits[30:0], sig_nrz};
        end
    endtask

    task automatic bit_len(output int hi, output int lo);
        hi = 0;
        lo = 0;
        for (int i = 0; i < 200; i++) begin
            if (sig_bclk) hi++;
            else lo++;
            @(posedge clk);
            #1;
            if (bit_stb || !busy) break;
        end
    endtask

    initial begin
        logic [31:0] bits;
        logic [13:0] first14;
        bit          dbits [0:253];
        int          g, hi, lo, c, ones, bad;

        for (int i = 0; i < 7; i++) seq[i] = 1'b1;
        for (int i = 7; i < 254; i++) seq[i] = seq[i-7] ^ seq[i-6];

        for (int i = 0; i < 14; i++) first14[13-i] = seq[i];
        check("model_first14", {18'd0, first14}, {18'd0, 14'b11111110000001});
        ones = 0;
        for (int i = 0; i < 127; i++) ones += int'(seq[i]);
        check("model_ones127", ones, 64);
        bad = 0;
        for (int i = 0; i < 127; i++) if (seq[i] != seq[i+127]) bad++;
        check("model_period127", bad, 0);

        repeat (3) @(negedge clk);
        check("reset_outputs", {27'd0, busy, sig_nrz, sig_bclk, sig_man, bit_stb}, 0);

        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
        bad   = 0;
        for (int i = 0; i < 254; i++) begin
            next_stb(g);
            dbits[i] = sig_nrz;
            if (i > 0 && g != 4) bad++;
        end
        bits = '0;
        for (int i = 0; i < 7; i++) bits = {bits[30:0], dbits[i]};
        check("prbs_first7", bits, 32'h7F);
        check("prbs_stb_every4", bad, 0);
        ones = 0;
        for (int i = 0; i < 127; i++) ones += int'(dbits[i]);
        check("prbs_ones_win0", ones, 64);
        ones = 0;
        for (int i = 50; i < 177; i++) ones += int'(dbits[i]);
        check("prbs_ones_win50", ones, 64);
        bad = 0;
        for (int i = 0; i < 127; i++) if (dbits[i] != dbits[i+127]) bad++;
        check("prbs_period", bad, 0);

        @(negedge clk);
        rate_sel = 4'd3;
        next_stb(g);
        bit_len(hi, lo);
        check("rate3_bclk_hi", hi, 8);
        check("rate3_bclk_lo", lo, 8);
        @(negedge clk);
        rate_sel = 4'd0;
        bit_len(hi, lo);
        check("rate_chg_cur_bit", hi + lo, 16);
        bit_len(hi, lo);
        check("rate_chg_next_hi", hi, 2);
        check("rate_chg_next_lo", lo, 2);

        @(negedge clk);
        mode    = 2'b01;
        pattern = 8'hA5;
        bits    = '0;
        bad     = 0;
        for (int i = 0; i < 16; i++) begin
            next_stb(g);
            bits = {bits[30:0], sig_nrz};
            if (sig_man != ~sig_nrz) bad++;
            repeat (BH) @(posedge clk);
            #1;
            if (sig_man != sig_nrz) bad++;
        end
        check("pattern_A5A5", bits, 32'hA5A5);
        check("pattern_man_halves", bad, 0);

        @(negedge clk);
        mode = 2'b10;
        collect(4, bits);
        check("mode10_ones", bits, 32'hF);
        @(negedge clk);
        mode = 2'b11;
        collect(6, bits);
        check("mode11_alt", bits, 32'b101010);

        @(negedge clk);
        mode     = 2'b00;
        rate_sel = 4'd1;
        next_stb(g);
        c = 1;
        @(posedge clk);
        #1;
        if (busy) c++;
        @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (!busy) break;
            c++;
        end
        check("en_drop_bit_len", c, 8);
        check("en_drop_idle_out", {27'd0, busy, sig_nrz, sig_bclk, sig_man, bit_stb}, 0);
        repeat (5) @(posedge clk);
        #1;
        check("en_drop_stays_idle", {27'd0, busy, sig_nrz, sig_bclk, sig_man, bit_stb}, 0);

        @(negedge clk);
        en = 1'b1;
        next_stb(g);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (!sig_bclk) break;
        end
        check("pre_reset_second_half", {30'd0, busy, sig_bclk}, 32'b10);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_out", {27'd0, busy, sig_nrz, sig_bclk, sig_man, bit_stb}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        rate_sel = 4'd0;
        collect(7, bits);
        check("restart_first7", bits, 32'h7F);

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if ($urandom_range(0, 29) == 0) en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) rate_sel = RW'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) pattern = 8'($urandom);
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 999) == 0) rst_n = 1'b0;
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/prbs_man_gen.md
PRBS_MAN_GEN -- requirements
Module: prbs_man_gen

Interface
REQ-001 Parameter LFSR_N, default 7: PRBS order; legal values 7, 9, 15, 23; any other value is a synthesis error.
REQ-002 Parameter RATE_W, default 4: width of rate_sel.
REQ-003 Parameter BASE_HALF, default 1000: half-bit period in clk cycles at rate_sel=0; legal range >=1.
REQ-004 clk  input  1  system clock; all logic is on the rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 en  input  1  run request; sampled at bit boundaries and in IDLE.
REQ-007 rate_sel  input  RATE_W  rate index; half-bit period HALF = BASE_HALF*(rate_sel+1) cycles.
REQ-008 mode  input  2  00 PRBS, 01 8-bit pattern, 10 all-ones, 11 alternating 1010...
REQ-009 pattern  input  8  repeating word used in mode 01, sent MSB first.
REQ-010 sig_nrz  output  1  current data bit (NRZ).
REQ-011 sig_bclk  output  1  bit clock; 1 in the first half-bit, 0 in the second.
REQ-012 sig_man  output  1  Manchester line, IEEE 802.3 convention: 1 = low then high, 0 = high then low.
REQ-013 bit_stb  output  1  one-cycle pulse in the first cycle of every bit.
REQ-014 busy  output  1  high whenever the state is not IDLE.

Function
REQ-015 FSM states SHALL be IDLE, FIRST_HALF and SECOND_HALF.
REQ-016 IDLE->FIRST_HALF SHALL occur on the edge where en=1 is sampled: that edge loads the first bit into sig_nrz, sets sig_bclk=1, pulses bit_stb, and latches rate_sel and mode.
REQ-017 FIRST_HALF SHALL last exactly HALF cycles, then go to SECOND_HALF with sig_bclk=0.
REQ-018 SECOND_HALF SHALL last exactly HALF cycles; at its end, en=1 goes to FIRST_HALF with the next bit and re-latches rate_sel and mode; en=0 goes to IDLE.
REQ-019 Entering IDLE SHALL drive sig_nrz, sig_bclk, sig_man and bit_stb to 0.
REQ-020 en deasserted mid-bit SHALL NOT truncate the bit; the current bit always completes.
REQ-021 rate_sel, mode and pattern changes mid-bit SHALL take effect only at the next bit boundary; the period of the current bit is never altered.
REQ-022 sig_man SHALL equal sig_nrz XOR sig_bclk while busy, be registered, and change in the same cycle as sig_bclk.
REQ-023 The half-period counter SHALL be sized to hold BASE_HALF*2^RATE_W without overflow.
REQ-024 PRBS SHALL be a Fibonacci LFSR of LFSR_N bits, shift left, with output bit = MSB; the feedback polynomial SHALL be x^LFSR_N + x^t + 1 with tap t = 6 (N=7), 5 (N=9), 14 (N=15), 18 (N=23); period = 2^LFSR_N-1.
REQ-025 The LFSR seed SHALL be all ones; if the state is ever all zeros, it SHALL reload the seed on the next advance.
REQ-026 The LFSR SHALL advance only at bit boundaries while mode=00; it holds in other modes and in IDLE, and resumes where it stopped.
REQ-027 Mode 01 SHALL capture pattern when the bit index is 0, send pattern[7] down to pattern[0], wrap 7->0, and reset the bit index to 0 on any mode change.
REQ-028 The mode 11 sequence SHALL start with 1 on entry to mode 11.

Reset
REQ-029 While rst_n=0: state IDLE, all outputs 0, LFSR = all ones, counters and bit index 0, latched rate 0, latched mode 00.
REQ-030 Reset asserted mid-bit SHALL abort immediately with no bit completion; after release, the block behaves as from power-up.

Verification
REQ-031 LFSR_N=7, BASE_HALF=2, rate_sel=0, mode=00, en held 1 -> 127-bit period, first 7 bits 1111111, bit_stb every 4 cycles, every 127-bit window contains 64 ones.
REQ-032 BASE_HALF=2, rate_sel=3 -> sig_bclk high 8 cycles and low 8 cycles; rate_sel changed to 0 mid-bit -> current bit stays 16 cycles, next bit is 4 cycles.
REQ-033 mode=01, pattern=8'hA5 -> sig_nrz 10100101 repeating; sig_man per bit is 1:0->1 or 0:1->0 at half-bit, checked against decoded NRZ.
REQ-034 en dropped 1 cycle after bit_stb -> bit completes full 2*HALF, then busy=0 and all outputs 0.
REQ-035 rst_n pulsed low mid-SECOND_HALF -> outputs 0 within the same cycle (asynchronous); after release with en=1 the PRBS restarts at seed (first bits 1111111).
REQ-036 mode 10 -> sig_nrz constant 1 with sig_man a square wave at the bit rate; mode 11 -> 1,0,1,0... starting with 1.
